mem_access_unit: RTL



---
 rtl/mem_access_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Data-memory stage: runs loads/stores on a req/ack bus and stalls the core.
// Ports: clk/reset, Mem* controls, Addr/WriteData in, ReadData/Stall/Fault out, bus_* side.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ByteAcc,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // last WAIT cycle index before the access is abandoned
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       fault_q;
  logic       byte_q;
  logic [1:0] lane_q;
  logic       req;
  logic       misal;
  logic [7:0] rbyte;

  assign req   = MemRead | MemWrite;
  assign misal = !ByteAcc && (Addr[1:0] != 2'b00);

  always_comb begin
    rbyte = bus_rdata[7:0];
    unique case (lane_q)
      2'd0: rbyte = bus_rdata[7:0];
      2'd1: rbyte = bus_rdata[15:8];
      2'd2: rbyte = bus_rdata[23:16];
      2'd3: rbyte = bus_rdata[31:24];
    endcase
  end

  always_comb begin
    Stall = 1'b0;
    unique case (state)
      IDLE:    Stall = req;
      WAIT:    Stall = 1'b1;
      default: Stall = 1'b0;
    endcase
  end

  assign bus_req = (state == WAIT);
  assign Fault   = (state == DONE) & fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      fault_q   <= 1'b0;
      byte_q    <= 1'b0;
      lane_q    <= 2'd0;
      ReadData  <= 32'd0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            // a store wins when both strobes are set
            bus_we   <= MemWrite;
            bus_addr <= {Addr[31:2], 2'b00};
            byte_q   <= ByteAcc;
            lane_q   <= Addr[1:0];
            cnt      <= 8'd0;
            if (ByteAcc) begin
              bus_be    <= 4'b0001 << Addr[1:0];
              bus_wdata <= {4{WriteData[7:0]}};
            end else begin
              bus_be    <= 4'b1111;
              bus_wdata <= WriteData;
            end
            if (misal) begin
              fault_q  <= 1'b1;
              ReadData <= 32'd0;
              state    <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus_ack) begin
            if (!bus_we)
              ReadData <= byte_q ? {24'd0, rbyte} : bus_rdata;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            fault_q  <= 1'b1;
            ReadData <= 32'd0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          fault_q <= 1'b0;
          cnt     <= 8'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
